dc_remove_scheduler: RTL and testbench
======================================

# dc_remove_scheduler

Time-multiplexed DC-removal engine that shares one multiply/accumulate datapath among `NUM_CH` audio channels, for example the reference and error microphones. Each channel's one-pole high-pass state (previous input, previous output) is held locally. A round-robin scheduler services channels with pending samples through a 3-state FSM. The block sits between the ADC deserialisers and the adaptive filter, and produces one tagged output stream.

## Interface
- `NUM_CH`, 2, number of channels (2..8)
- `ALPHA_MULTIPLIER`, 511, signed pole coefficient numerator
- `ALPHA_SHIFT_SIZE`, 9, coefficient denominator exponent (alpha = 511/512)
- `clk_in`  in  1  system clock; the only clock domain
- `reset_in`  in  1  asynchronous, active-high reset
- `ready_in`  in  NUM_CH  per-channel 1-cycle sample strobe
- `signal_in`  in  16*NUM_CH  signed samples; channel i occupies bits [16i+15:16i]
- `flush_in`  in  1  synchronous; zeroes the history of every channel
- `done_out`  out  1  1-cycle strobe; `signal_out`/`ch_out` valid
- `ch_out`  out  clog2(NUM_CH)  channel index of the current output
- `signal_out`  out  16  signed filtered sample
- `overrun_out`  out  NUM_CH  sticky per-channel overrun flag; cleared only by reset

## Operation
- **Input capture.** Each channel has a 16-bit holding register `hold[i]` and a `pending[i]` flag.
  - `ready_in[i]` high at an edge: `hold[i] <= slice i`, `pending[i] <= 1`.
  - If `pending[i]` was already 1 and channel i is not granted at that edge, the old sample is overwritten and `overrun_out[i] <= 1`.
  - If channel i is granted at the same edge as a new `ready_in[i]`, the new sample becomes pending (set wins over clear). This is not an overrun.
- **Per-channel state.** `xp[i]` and `yp[i]`, both 16-bit signed, reset to 0.
- **Arbiter.** Round-robin with pointer `rr`, reset value 0.
  - Grant goes to the first pending channel at or after `rr`, wrapping modulo `NUM_CH`.
  - After granting channel g, `rr <= (g+1) mod NUM_CH`.
- **FSM states.** IDLE, MUL, ACC.
  - IDLE: if any pending, grant g. Latch `x=hold[g]`, `xp[g]`, `yp[g]` and `g`; clear `pending[g]`; go to MUL. Otherwise stay in IDLE.
  - MUL: register `prod = ALPHA_MULTIPLIER * yp` (27-bit signed) and `diff = (x - xp) <<< ALPHA_SHIFT_SIZE` (27-bit signed); go to ACC.
  - ACC:
    - Compute `acc = diff + prod` (28-bit signed) and `y = acc >>> ALPHA_SHIFT_SIZE` (arithmetic, floor).
    - Saturate `y` to [-32768, 32767].
    - Register `signal_out <= y_sat`, `ch_out <= g`, `done_out <= 1`.
    - Write back `xp[g] <= x` and `yp[g] <= y_sat`.
    - If any channel is pending, perform the IDLE grant in this same cycle and go to MUL. Otherwise go to IDLE.
- **Flush.** `flush_in` zeroes all `xp`/`yp` at the next edge.
  - Flush takes priority over an ACC write-back in the same cycle.
  - The ACC output is still emitted, with its pre-flush value.
  - `pending`, `hold` and the FSM are unaffected.
- **Reset.** Asynchronous; everything returns to its reset value immediately.
  - Reset values: `done_out=0`, `signal_out=0`, `ch_out=0`, `overrun_out=0`; all `pending`, `hold`, `xp`, `yp`, `rr` = 0; FSM = IDLE.
  - A sample in flight at reset is dropped.

## Timing
- **Latency.** With `ready_in[i]` sampled at edge E0 and the FSM idle with no other pending channel:
  - grant at E1;
  - MUL result registered at E2;
  - `done_out` high for the one cycle following E3.
- **Throughput.** One sample every 2 cycles under continuous load, since ACC chains directly into MUL. Aggregate input rate must not exceed 1 per 2 cycles, or overruns occur.
- **Output stability.** `done_out` is never high on two consecutive cycles. `signal_out` and `ch_out` hold their value until the next `done_out`.
- **Output order.** The order of outputs equals the order of grants.

## Test plan
- **Step response.** After reset, ch0 gets `x=1000` then `x=1000`, spaced ≥4 cycles apart. Required: `signal_out=1000` then `998`, with `ch_out=0`, and `done_out` exactly 3 cycles after each strobe.
- **Saturation.** ch1 gets 32767 then -32768. Required: outputs 32767 then -32768 (saturated from -32832), and `yp[1] = -32768`.
- **Simultaneous arrival and round-robin.** `ready_in=2'b11` with values ch0=100, ch1=200 in one cycle, after reset. Required: ch0 output 100, then ch1 output 200, 2 cycles apart. Repeating this, `rr` alternates the service order so that ch1 is first on the next simultaneous arrival.
- **Overrun.** Two ch0 strobes on consecutive cycles while the FSM is busy with ch1. Required: `overrun_out[0]=1` and sticky; only the second value is filtered. A strobe on the exact grant edge does not set overrun.
- **Flush.** Feed ch0 = 1000, 1000, then pulse `flush_in`, then feed 1000. Required: the third output is 1000, i.e. history was cleared.
- **Reset mid-operation.** Assert `reset_in` asynchronously while in MUL. Required: `done_out` stays 0 and all outputs read 0 immediately. The first post-reset sample of 500 yields 500.

Source files
------------

// File: rtl/dc_remove_scheduler.sv
// ============================================================================
// dc_remove_scheduler
//   Time-multiplexed one-pole DC-removal (high-pass) engine. One shared
//   multiply/accumulate datapath serves NUM_CH channels. Each channel keeps
//   its own capture register and filter history. A round-robin arbiter feeds
//   the datapath through an IDLE -> MUL -> ACC FSM.
//
//   y[n] = x[n] - x[n-1] + alpha * y[n-1],  alpha = ALPHA_MULTIPLIER / 2^ALPHA_SHIFT_SIZE
//
// Ports
//   clk_in       : system clock
//   reset_in     : asynchronous, active-high reset
//   ready_in     : per-channel 1-cycle sample strobe          [NUM_CH]
//   signal_in    : packed signed samples, ch i at [16i+15:16i] [16*NUM_CH]
//   flush_in     : synchronous clear of every channel's history
//   done_out     : 1-cycle strobe, signal_out/ch_out valid
//   ch_out       : channel index of the current output
//   signal_out   : signed filtered sample                      [16]
//   overrun_out  : sticky per-channel overrun flags            [NUM_CH]
//
// dc_remove_chan (per-channel slice, instantiated once per channel)
//   Holds hold/pending/overrun capture state and xp/yp filter history.
// ============================================================================
module dc_remove_scheduler #(
   parameter int NUM_CH           = 2,
   parameter int ALPHA_MULTIPLIER = 511,
   parameter int ALPHA_SHIFT_SIZE = 9,
   localparam int CW              = $clog2(NUM_CH)
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic [NUM_CH-1:0]      ready_in,
   input  logic [16*NUM_CH-1:0]   signal_in,
   input  logic                   flush_in,
   output logic                   done_out,
   output logic [CW-1:0]          ch_out,
   output logic [15:0]            signal_out,
   output logic [NUM_CH-1:0]      overrun_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;

   localparam logic signed [26:0] ALPHA_C = 27'(ALPHA_MULTIPLIER);

   // per-channel views
   logic [NUM_CH-1:0][15:0] hold_w;
   logic [NUM_CH-1:0][15:0] xp_w;
   logic [NUM_CH-1:0][15:0] yp_w;
   logic [NUM_CH-1:0]       pending_w;
   logic [NUM_CH-1:0]       grant_w;
   logic [NUM_CH-1:0]       wb_w;

   // control / datapath registers
   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           rr_q, rr_d;
   logic [CW-1:0]           g_q, g_d;
   logic [15:0]             x_q, x_d;
   logic [15:0]             xpl_q, xpl_d;
   logic [15:0]             ypl_q, ypl_d;
   logic signed [26:0]      prod_q, prod_d;
   logic signed [26:0]      diff_q, diff_d;
   logic                    done_q, done_d;
   logic [CW-1:0]           ch_q, ch_d;
   logic [15:0]             sig_q, sig_d;

   // arbiter
   logic                    gnt_any_w;
   logic [CW-1:0]           gnt_idx_w;
   logic                    do_grant_w;

   // ACC arithmetic
   logic signed [26:0]      dx_w;
   logic signed [26:0]      yp27_w;
   logic signed [27:0]      acc_w;
   logic signed [27:0]      ysh_w;
   logic [15:0]             ysat_w;

   // -------------------------------------------------------------------------
   // Channel slices
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign grant_w[i] = do_grant_w && (gnt_idx_w == CW'(i));
      assign wb_w[i]    = (state_q == S_ACC) && (g_q == CW'(i));

      dc_remove_chan u_ch (
         .clk_i     (clk_in),
         .reset_i   (reset_in),
         .ready_i   (ready_in[i]),
         .sample_i  (signal_in[16*i +: 16]),
         .grant_i   (grant_w[i]),
         .flush_i   (flush_in),
         .wb_i      (wb_w[i]),
         .wb_x_i    (x_q),
         .wb_y_i    (ysat_w),
         .hold_o    (hold_w[i]),
         .pending_o (pending_w[i]),
         .overrun_o (overrun_out[i]),
         .xp_o      (xp_w[i]),
         .yp_o      (yp_w[i])
      );
   end

   // -------------------------------------------------------------------------
   // Round-robin arbiter: first pending channel at or after rr_q.
   // Scanning from the far end down lets the nearest candidate win last.
   // -------------------------------------------------------------------------
   always_comb begin
      logic [CW:0] idx;
      gnt_any_w = 1'b0;
      gnt_idx_w = '0;
      idx       = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = {1'b0, rr_q} + (CW+1)'(k);
         if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
         if (pending_w[idx[CW-1:0]]) begin
            gnt_any_w = 1'b1;
            gnt_idx_w = idx[CW-1:0];
         end
      end
   end

   // ACC chains straight into the next grant, so both IDLE and ACC may grant.
   assign do_grant_w = gnt_any_w && ((state_q == S_IDLE) || (state_q == S_ACC));

   // -------------------------------------------------------------------------
   // Datapath arithmetic
   // -------------------------------------------------------------------------
   assign dx_w   = $signed({{11{x_q[15]}}, x_q}) - $signed({{11{xpl_q[15]}}, xpl_q});
   assign yp27_w = $signed({{11{ypl_q[15]}}, ypl_q});
   assign acc_w  = {diff_q[26], diff_q} + {prod_q[26], prod_q};
   assign ysh_w  = acc_w >>> ALPHA_SHIFT_SIZE;

   always_comb begin
      if (ysh_w > 28'sd32767)       ysat_w = 16'h7fff;
      else if (ysh_w < -28'sd32768) ysat_w = 16'h8000;
      else                          ysat_w = ysh_w[15:0];
   end

   // -------------------------------------------------------------------------
   // FSM / next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      g_d     = g_q;
      x_d     = x_q;
      xpl_d   = xpl_q;
      ypl_d   = ypl_q;
      prod_d  = prod_q;
      diff_d  = diff_q;
      done_d  = 1'b0;
      ch_d    = ch_q;
      sig_d   = sig_q;

      case (state_q)
         S_IDLE: if (do_grant_w) state_d = S_MUL;
         S_MUL: begin
            prod_d  = ALPHA_C * yp27_w;
            diff_d  = dx_w <<< ALPHA_SHIFT_SIZE;
            state_d = S_ACC;
         end
         S_ACC: begin
            done_d  = 1'b1;
            sig_d   = ysat_w;
            ch_d    = g_q;
            state_d = gnt_any_w ? S_MUL : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (do_grant_w) begin
         g_d = gnt_idx_w;
         x_d = hold_w[gnt_idx_w];
         // History is read at the same edge it may be cleared or rewritten,
         // so pick up the value the channel will hold after this edge.
         if (flush_in) begin
            xpl_d = '0;
            ypl_d = '0;
         end else if ((state_q == S_ACC) && (g_q == gnt_idx_w)) begin
            xpl_d = x_q;
            ypl_d = ysat_w;
         end else begin
            xpl_d = xp_w[gnt_idx_w];
            ypl_d = yp_w[gnt_idx_w];
         end
         if (gnt_idx_w == CW'(NUM_CH - 1)) rr_d = '0;
         else                              rr_d = gnt_idx_w + CW'(1);
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         g_q     <= '0;
         x_q     <= '0;
         xpl_q   <= '0;
         ypl_q   <= '0;
         prod_q  <= '0;
         diff_q  <= '0;
         done_q  <= 1'b0;
         ch_q    <= '0;
         sig_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         g_q     <= g_d;
         x_q     <= x_d;
         xpl_q   <= xpl_d;
         ypl_q   <= ypl_d;
         prod_q  <= prod_d;
         diff_q  <= diff_d;
         done_q  <= done_d;
         ch_q    <= ch_d;
         sig_q   <= sig_d;
      end
   end

   assign done_out   = done_q;
   assign ch_out     = ch_q;
   assign signal_out = sig_q;

endmodule

// ----------------------------------------------------------------------------
// dc_remove_chan: capture register, pending/overrun flags and filter history
// for one channel.
// ----------------------------------------------------------------------------
module dc_remove_chan (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        ready_i,
   input  logic [15:0] sample_i,
   input  logic        grant_i,
   input  logic        flush_i,
   input  logic        wb_i,
   input  logic [15:0] wb_x_i,
   input  logic [15:0] wb_y_i,
   output logic [15:0] hold_o,
   output logic        pending_o,
   output logic        overrun_o,
   output logic [15:0] xp_o,
   output logic [15:0] yp_o
);

   logic [15:0] hold_q, hold_d;
   logic        pending_q, pending_d;
   logic        overrun_q, overrun_d;
   logic [15:0] xp_q, xp_d;
   logic [15:0] yp_q, yp_d;

   always_comb begin
      hold_d    = hold_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      xp_d      = xp_q;
      yp_d      = yp_q;

      // A new strobe beats the grant's clear; overwriting a sample nobody
      // has picked up yet is the only overrun case.
      if (ready_i) begin
         hold_d    = sample_i;
         pending_d = 1'b1;
         if (pending_q && !grant_i) overrun_d = 1'b1;
      end else if (grant_i) begin
         pending_d = 1'b0;
      end

      if (flush_i) begin
         xp_d = '0;
         yp_d = '0;
      end else if (wb_i) begin
         xp_d = wb_x_i;
         yp_d = wb_y_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         hold_q    <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         xp_q      <= '0;
         yp_q      <= '0;
      end else begin
         hold_q    <= hold_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         xp_q      <= xp_d;
         yp_q      <= yp_d;
      end
   end

   assign hold_o    = hold_q;
   assign pending_o = pending_q;
   assign overrun_o = overrun_q;
   assign xp_o      = xp_q;
   assign yp_o      = yp_q;

endmodule

// File: tb/tb_dc_remove_scheduler.sv
// Testbench for dc_remove_scheduler (NUM_CH = 2). A cycle-by-cycle vector
// table covers step response, saturation and round-robin ordering; short
// hand-written sequences cover overrun, grant-edge strobe, flush and
// asynchronous reset.
module tb_dc_remove_scheduler;

   logic        clk_in;
   logic        reset_in;
   logic [1:0]  ready_in;
   logic [31:0] signal_in;
   logic        flush_in;
   logic        done_out;
   logic [0:0]  ch_out;
   logic [15:0] signal_out;
   logic [1:0]  overrun_out;

   int checks = 0;
   int errors = 0;

   dc_remove_scheduler #(
      .NUM_CH(2), .ALPHA_MULTIPLIER(511), .ALPHA_SHIFT_SIZE(9)
   ) dut (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .ready_in    (ready_in),
      .signal_in   (signal_in),
      .flush_in    (flush_in),
      .done_out    (done_out),
      .ch_out      (ch_out),
      .signal_out  (signal_out),
      .overrun_out (overrun_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic               rst;
      logic [1:0]         rdy;
      logic signed [15:0] s0;
      logic signed [15:0] s1;
      logic               fl;
      logic               done;
      logic [0:0]         ch;
      logic signed [15:0] sig;
      logic [1:0]         ovr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic [1:0] rdy, int s0, int s1, logic fl,
                               logic done, logic [0:0] ch, int sig, logic [1:0] ovr);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.s0 = 16'(s0); v.s1 = 16'(s1); v.fl = fl;
      v.done = done; v.ch = ch; v.sig = 16'(sig); v.ovr = ovr;
      return v;
   endfunction

   task automatic chk(input string name, input logic ed, input logic [0:0] ec,
                      input int es, input logic [1:0] eo);
      logic signed [15:0] es16;
      es16 = 16'(es);
      checks++;
      if (done_out !== ed || ch_out !== ec || signal_out !== es16 || overrun_out !== eo) begin
         errors++;
         $display("FAIL %s: got done=%0b ch=%0d sig=%0d ovr=%b, want done=%0b ch=%0d sig=%0d ovr=%b",
                  name, done_out, ch_out, $signed(signal_out), overrun_out,
                  ed, ec, es16, eo);
      end
   endtask

   // Drive one cycle of inputs at a negedge and return at the next negedge.
   task automatic cyc(input logic [1:0] rdy, input int s0, input int s1, input logic fl);
      ready_in  = rdy;
      signal_in = {16'(s1), 16'(s0)};
      flush_in  = fl;
      @(negedge clk_in);
   endtask

   task automatic do_reset();
      reset_in = 1'b1;
      cyc(2'b00, 0, 0, 1'b0);
      reset_in = 1'b0;
   endtask

   // One ch0 sample on an idle engine; returns right after its done cycle.
   task automatic single0(input int s0);
      cyc(2'b01, s0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
   endtask

   initial begin
      reset_in  = 1'b1;
      ready_in  = '0;
      signal_in = '0;
      flush_in  = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      chk("reset_state", 1'b0, 1'b0, 0, 2'b00);
      reset_in = 1'b0;

      // ---- step response ----
      tbl.push_back(mk(0, 2'b01, 1000, 0, 0, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 0, 1000, 2'b00));
      tbl.push_back(mk(0, 2'b01, 1000, 0, 0, 0, 0, 1000, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 1000, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 1000, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 0, 998, 2'b00));
      // ---- saturation on ch1 ----
      tbl.push_back(mk(0, 2'b10, 0, 32767, 0, 0, 0, 998, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 998, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 998, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 1, 32767, 2'b00));
      tbl.push_back(mk(0, 2'b10, 0, -32768, 0, 0, 1, 32767, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 32767, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 32767, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 1, -32768, 2'b00));
      // same input again: 511*(-32768)/512 = -32704 proves yp[1] = -32768
      tbl.push_back(mk(0, 2'b10, 0, -32768, 0, 0, 1, -32768, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, -32768, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, -32768, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 1, -32704, 2'b00));
      // ---- simultaneous arrival after reset ----
      tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 2'b11, 100, 200, 0, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 0, 100, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 100, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 1, 200, 2'b00));
      // ch0 alone moves rr to 1 (ch0 history 100/100 -> 99)
      tbl.push_back(mk(0, 2'b01, 100, 0, 0, 0, 1, 200, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 200, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 200, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 0, 99, 2'b00));
      // simultaneous with rr=1: ch1 first (200/200 -> 199), then ch0 (100/99 -> 98)
      tbl.push_back(mk(0, 2'b11, 100, 200, 0, 0, 0, 99, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 99, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 99, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 1, 199, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 199, 2'b00));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 1, 0, 98, 2'b00));

      for (int i = 0; i < tbl.size(); i++) begin
         reset_in = tbl[i].rst;
         cyc(tbl[i].rdy, int'(tbl[i].s0), int'(tbl[i].s1), tbl[i].fl);
         chk($sformatf("vec%0d", i), tbl[i].done, tbl[i].ch, int'(tbl[i].sig), tbl[i].ovr);
      end
      reset_in = 1'b0;

      // ---- overrun: two ch0 strobes while ch1 is in flight ----
      do_reset();
      cyc(2'b10, 0, 300, 1'b0);
      cyc(2'b01, 111, 0, 1'b0);
      chk("ovr_first_strobe", 1'b0, 1'b0, 0, 2'b00);
      cyc(2'b01, 222, 0, 1'b0);
      chk("ovr_set", 1'b0, 1'b0, 0, 2'b01);
      cyc(2'b00, 0, 0, 1'b0);
      chk("ovr_ch1_out", 1'b1, 1'b1, 300, 2'b01);
      cyc(2'b00, 0, 0, 1'b0);
      chk("ovr_gap", 1'b0, 1'b1, 300, 2'b01);
      cyc(2'b00, 0, 0, 1'b0);
      chk("ovr_second_val", 1'b1, 1'b0, 222, 2'b01);
      repeat (3) cyc(2'b00, 0, 0, 1'b0);
      chk("ovr_sticky", 1'b0, 1'b0, 222, 2'b01);

      // ---- strobe on the grant edge: no overrun, history forwarded ----
      do_reset();
      chk("ovr_cleared_by_reset", 1'b0, 1'b0, 0, 2'b00);
      cyc(2'b01, 50, 0, 1'b0);
      cyc(2'b01, 60, 0, 1'b0);
      chk("grant_edge_no_ovr", 1'b0, 1'b0, 0, 2'b00);
      cyc(2'b00, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      chk("grant_edge_out1", 1'b1, 1'b0, 50, 2'b00);
      cyc(2'b00, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      chk("grant_edge_out2", 1'b1, 1'b0, 59, 2'b00);

      // ---- flush ----
      do_reset();
      single0(1000);
      chk("flush_pre1", 1'b1, 1'b0, 1000, 2'b00);
      single0(1000);
      chk("flush_pre2", 1'b1, 1'b0, 998, 2'b00);
      cyc(2'b00, 0, 0, 1'b1);
      chk("flush_quiet", 1'b0, 1'b0, 998, 2'b00);
      single0(1000);
      chk("flush_cleared", 1'b1, 1'b0, 1000, 2'b00);
      // flush on the ACC edge: output still emitted, write-back suppressed
      cyc(2'b01, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b1);
      chk("flush_acc_emit", 1'b1, 1'b0, -2, 2'b00);
      single0(0);
      chk("flush_acc_prio", 1'b1, 1'b0, 0, 2'b00);

      // ---- asynchronous reset while in MUL ----
      do_reset();
      cyc(2'b10, 0, 700, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      chk("rst_pre", 1'b1, 1'b1, 700, 2'b00);
      cyc(2'b01, 500, 0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0);
      #2 reset_in = 1'b1;
      #1 chk("rst_async", 1'b0, 1'b0, 0, 2'b00);
      @(negedge clk_in);
      reset_in = 1'b0;
      repeat (4) cyc(2'b00, 0, 0, 1'b0);
      chk("rst_dropped", 1'b0, 1'b0, 0, 2'b00);
      single0(500);
      chk("rst_post", 1'b1, 1'b0, 500, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
